acc_drain_ctrl: RTL and testbench
=================================

Name: acc_drain_ctrl

Overview:
Read-side controller for the accumulator buffer. On a start command it reads a contiguous range of accumulator rows through the buffer's registered, saturating read port (enb/addrb, 1-cycle latency). It streams each saturated int8 row to the unified-buffer writeback path over a valid/ready interface. A small internal FIFO absorbs the fixed read latency, so downstream backpressure never loses or duplicates a row.

Parameters:
DATA_NUM, 16, int8 lanes per row
OUTPUT_DATA_SIZE, 8, bits per lane
DOUT_WIDTH, DATA_NUM*OUTPUT_DATA_SIZE, row width (128)
ADDR_WIDTH, 6, accumulator address width (RAM_DEPTH 64)
DST_ADDR_WIDTH, 8, destination address width
FIFO_DEPTH, 4, internal row FIFO entries (must be >= 3)

Ports:
clk  in  1  clock, all logic on rising edge
reset_n  in  1  synchronous active-low reset
start  in  1  command strobe, sampled only in IDLE
src_base  in  ADDR_WIDTH  first accumulator row
dst_base  in  DST_ADDR_WIDTH  destination address of first row
len  in  ADDR_WIDTH+1  number of rows (0..127)
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle completion pulse
acc_enb  out  1  accumulator read enable
acc_addrb  out  ADDR_WIDTH  accumulator read address
acc_doutb  in  DOUT_WIDTH  accumulator saturated read data, valid the cycle after acc_enb
m_valid  out  1  output row valid
m_ready  in  1  downstream accept
m_data  out  DOUT_WIDTH  output row
m_addr  out  DST_ADDR_WIDTH  destination address of the row
m_last  out  1  high on the final row of the command

Behaviour:
- Reset (reset_n=0 at an edge): state=IDLE. busy=0, done=0, acc_enb=0, acc_addrb=0, m_valid=0, m_last=0, m_data=0, m_addr=0. FIFO empty, counters cleared, in-flight flag cleared.
- Reset mid-command aborts it: no done pulse, no further beats. The pending acc_doutb return is discarded.
- States:
  - IDLE: start=1 latches src_base/dst_base/len. Goes to RUN if len>0, else to DONE.
  - RUN: issues reads and drains rows. Goes to DONE at the edge where the len-th row handshakes.
  - DONE: done=1 and busy=0 for exactly one cycle, then back to IDLE.
- start while not IDLE is ignored. Latched operands are stable for the whole command.
- Read issue:
  - acc_enb is asserted in RUN when reads_issued<len and (fifo_count + inflight) <= FIFO_DEPTH-2. inflight = acc_enb of the previous cycle.
  - acc_addrb = (src_base + reads_issued) mod 2^ADDR_WIDTH, so addresses wrap 63 -> 0.
  - acc_enb is never asserted outside RUN.
- Capture: in the cycle after acc_enb=1, acc_doutb is written into the FIFO tail together with (dst_base + index) mod 2^DST_ADDR_WIDTH and last=(index==len-1).
- The FIFO cannot overflow given the issue rule. Simultaneous push and pop leaves fifo_count unchanged.
- Output:
  - m_valid = FIFO not empty. m_data/m_addr/m_last come from the FIFO head.
  - Pop occurs on m_valid && m_ready.
  - While m_valid=1 and m_ready=0, m_data/m_addr/m_last hold stable.
- Latency and throughput:
  - start accepted at edge T: acc_enb first high in cycle T+1, first m_valid in cycle T+3.
  - With m_ready held high, one row per cycle sustained with no bubbles.
  - Last handshake at edge E: done=1 in cycle E+1.
- len=0: IDLE -> DONE. done pulses in the cycle after start, with zero reads and zero beats.
- len>64: addresses wrap and rows are re-read. This is legal, with no special handling.
- No combinational path from m_ready to m_valid/m_data. acc_enb depends only on registered state.

Test Plan:
- Reset, then start src_base=0 dst_base=0x10 len=4, m_ready=1 -> acc_enb cycles T+1..T+4 with addrb 0..3. Beats cycles T+3..T+6 with m_addr 0x10..0x13 and m_last on 0x13. done=1 in cycle T+7.
- src_base=62 len=4 -> acc_addrb sequence 62,63,0,1. m_data matches the accumulator rows in that order.
- len=8, m_ready toggling 1,0,0,1,... -> exactly 8 beats in order. Data stable during stalls, acc_enb throttled, no row lost or duplicated.
- len=0 -> done one cycle after start, acc_enb and m_valid never asserted.
- Assert start again while busy with len=5 mid-command -> ignored. The original command completes unchanged.
- reset_n=0 for one cycle after the 2nd beat of a len=6 command -> all outputs at reset values, no done. A new start with len=2 then completes normally.

Source files
------------

// File: rtl/acc_drain_ctrl.sv
// Accumulator drain controller: reads a contiguous range of accumulator rows
// and streams them out over valid/ready. A small row FIFO absorbs the one-cycle
// read latency so that backpressure never drops or repeats a row.
module acc_drain_ctrl #(
  parameter int unsigned DATA_NUM         = 16,
  parameter int unsigned OUTPUT_DATA_SIZE = 8,
  parameter int unsigned DOUT_WIDTH       = DATA_NUM * OUTPUT_DATA_SIZE,
  parameter int unsigned ADDR_WIDTH       = 6,
  parameter int unsigned DST_ADDR_WIDTH   = 8,
  parameter int unsigned FIFO_DEPTH       = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [ADDR_WIDTH-1:0]     src_base,
  input  logic [DST_ADDR_WIDTH-1:0] dst_base,
  input  logic [ADDR_WIDTH:0]       len,
  output logic                      busy,
  output logic                      done,
  output logic                      acc_enb,
  output logic [ADDR_WIDTH-1:0]     acc_addrb,
  input  logic [DOUT_WIDTH-1:0]     acc_doutb,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [DOUT_WIDTH-1:0]     m_data,
  output logic [DST_ADDR_WIDTH-1:0] m_addr,
  output logic                      m_last
);

  localparam int unsigned LEN_W = ADDR_WIDTH + 1;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                    state_q, state_d;
  logic [ADDR_WIDTH-1:0]     src_q, src_d;
  logic [DST_ADDR_WIDTH-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]          len_q, len_d;
  logic [LEN_W-1:0]          issued_q, issued_d;
  logic [LEN_W-1:0]          cap_q, cap_d;
  logic [LEN_W-1:0]          beats_q, beats_d;
  logic                      enb_q, enb_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic                      inflight_q;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [PTR_W-1:0]          wr_ptr_q, rd_ptr_q;
  logic                      push, pop;

  logic [DOUT_WIDTH-1:0]     data_mem [FIFO_DEPTH];
  logic [DST_ADDR_WIDTH-1:0] addr_mem [FIFO_DEPTH];
  logic                      last_mem [FIFO_DEPTH];

  // Next-state, read-issue and FIFO occupancy logic.
  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    len_d    = len_q;
    cap_d    = cap_q;
    beats_d  = beats_q;
    issued_d = '0;
    enb_d    = 1'b0;
    addr_d   = addr_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    push     = inflight_q;
    pop      = (cnt_q != '0) && m_ready;
    cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);

    if (push) cap_d = cap_q + LEN_W'(1);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d   = src_base;
          dst_d   = dst_base;
          len_d   = len;
          cap_d   = '0;
          beats_d = '0;
          state_d = (len == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (pop) begin
          beats_d = beats_q + LEN_W'(1);
          if (beats_q == len_q - LEN_W'(1)) state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Reads issued before the next cycle; decide next cycle's read from
    // next cycle's occupancy plus the read returning in that cycle.
    issued_d = (state_q == S_RUN) ? issued_q + LEN_W'(enb_q) : '0;
    enb_d    = (state_d == S_RUN) && (issued_d < len_d) &&
               (({1'b0, cnt_d} + (CNT_W+1)'(enb_q)) <= (CNT_W+1)'(FIFO_DEPTH - 2));
    if (enb_d) addr_d = src_d + issued_d[ADDR_WIDTH-1:0];

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // State, command and FIFO registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      cap_q      <= '0;
      beats_q    <= '0;
      enb_q      <= 1'b0;
      addr_q     <= '0;
      inflight_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        data_mem[i] <= '0;
        addr_mem[i] <= '0;
        last_mem[i] <= 1'b0;
      end
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      cap_q      <= cap_d;
      beats_q    <= beats_d;
      enb_q      <= enb_d;
      addr_q     <= addr_d;
      inflight_q <= enb_q;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cnt_q      <= cnt_d;
      if (push) begin
        data_mem[wr_ptr_q] <= acc_doutb;
        addr_mem[wr_ptr_q] <= dst_q + DST_ADDR_WIDTH'(cap_q);
        last_mem[wr_ptr_q] <= (cap_q == len_q - LEN_W'(1));
        wr_ptr_q <= (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign acc_enb   = enb_q;
  assign acc_addrb = addr_q;
  assign m_valid   = (cnt_q != '0);
  assign m_data    = data_mem[rd_ptr_q];
  assign m_addr    = addr_mem[rd_ptr_q];
  assign m_last    = last_mem[rd_ptr_q];

endmodule

// File: tb/tb_acc_drain_ctrl.sv
// Directed bench for acc_drain_ctrl with a one-cycle-latency accumulator model.
module tb_acc_drain_ctrl;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [5:0]   src_base;
  logic [7:0]   dst_base;
  logic [6:0]   len;
  logic         busy, done, acc_enb, m_valid, m_ready, m_last;
  logic [5:0]   acc_addrb;
  logic [127:0] acc_doutb, m_data;
  logic [7:0]   m_addr;

  int checks = 0;
  int bad    = 0;
  int cyc    = 0;

  typedef struct {
    logic [127:0] d;
    logic [7:0]   a;
    logic         l;
    int           c;
  } beat_t;

  beat_t      beats[$];
  logic [5:0] enb_a[$];
  int         enb_c[$];
  int         done_c[$];

  logic         pv;
  logic [127:0] pd;
  logic [7:0]   pa;
  logic         pl;

  acc_drain_ctrl dut (
    .clk(clk), .reset_n(reset_n), .start(start), .src_base(src_base),
    .dst_base(dst_base), .len(len), .busy(busy), .done(done),
    .acc_enb(acc_enb), .acc_addrb(acc_addrb), .acc_doutb(acc_doutb),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_addr(m_addr), .m_last(m_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] row(input logic [5:0] a);
    return {8{{2'b10, a}, {2'b01, ~a}}};
  endfunction

  // Accumulator buffer read port: registered, one-cycle latency.
  always @(posedge clk) if (acc_enb) acc_doutb <= row(acc_addrb);

  // Event logger and stall-stability monitor.
  always @(negedge clk) begin
    beat_t b;
    if (reset_n) begin
      if (acc_enb) begin enb_a.push_back(acc_addrb); enb_c.push_back(cyc); end
      if (m_valid && m_ready) begin
        b.d = m_data; b.a = m_addr; b.l = m_last; b.c = cyc;
        beats.push_back(b);
      end
      if (done) done_c.push_back(cyc);
      if (pv) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== pd || m_addr !== pa || m_last !== pl) begin
          bad++;
          $display("FAIL stall_hold: valid=%b addr=%h last=%b, required valid=1 addr=%h last=%b",
                   m_valid, m_addr, m_last, pa, pl);
        end
      end
    end
    pv = reset_n && m_valid && !m_ready;
    pd = m_data; pa = m_addr; pl = m_last;
  end

  task automatic clear_logs();
    beats.delete(); enb_a.delete(); enb_c.delete(); done_c.delete();
  endtask

  // Issue a command; c0 is the cyc value seen in cycle T+1.
  task automatic issue(input logic [5:0] s, input logic [7:0] d, input logic [6:0] n,
                       output int c0);
    @(negedge clk);
    clear_logs();
    src_base = s; dst_base = d; len = n; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    c0 = cyc;
  endtask

  task automatic wait_done(input int max_cyc);
    int n = 0;
    while (done_c.size() == 0 && n < max_cyc) begin @(negedge clk); n++; end
    checks++;
    if (done_c.size() == 0) begin bad++; $display("FAIL done_timeout: no done within %0d cycles", max_cyc); end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_stream(input string nm, input logic [5:0] s, input logic [7:0] d, input int n);
    checks++;
    if (beats.size() != n) begin
      bad++; $display("FAIL %s_beat_count: got %0d, required %0d", nm, beats.size(), n);
    end
    checks++;
    if (enb_a.size() != n) begin
      bad++; $display("FAIL %s_read_count: got %0d, required %0d", nm, enb_a.size(), n);
    end
    for (int i = 0; i < n && i < beats.size(); i++) begin
      logic [5:0] ea = s + 6'(i);
      logic [7:0] eaddr = d + 8'(i);
      checks++;
      if (beats[i].d !== row(ea) || beats[i].a !== eaddr || beats[i].l !== (i == n - 1)) begin
        bad++;
        $display("FAIL %s_beat%0d: addr=%h last=%b data=%h, required addr=%h last=%b data=%h",
                 nm, i, beats[i].a, beats[i].l, beats[i].d, eaddr, (i == n - 1), row(ea));
      end
    end
    for (int i = 0; i < n && i < enb_a.size(); i++) begin
      logic [5:0] ea = s + 6'(i);
      checks++;
      if (enb_a[i] !== ea) begin
        bad++; $display("FAIL %s_addrb%0d: got %0d, required %0d", nm, i, enb_a[i], ea);
      end
    end
    checks++;
    if (done_c.size() != 1) begin
      bad++; $display("FAIL %s_done_count: got %0d, required 1", nm, done_c.size());
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || acc_enb !== 1'b0 || acc_addrb !== 6'd0 ||
        m_valid !== 1'b0 || m_last !== 1'b0 || m_data !== 128'd0 || m_addr !== 8'd0) begin
      bad++;
      $display("FAIL %s: busy=%b done=%b enb=%b addrb=%h valid=%b last=%b addr=%h data=%h, required all zero",
               nm, busy, done, acc_enb, acc_addrb, m_valid, m_last, m_addr, m_data);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; m_ready = 1'b1;
    src_base = '0; dst_base = '0; len = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset_values");
    reset_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_reset_idle");
  endtask

  task automatic test_basic();
    int c0;
    issue(6'd0, 8'h10, 7'd4, c0);
    checks++;
    if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy: got %b, required 1", busy); end
    wait_done(40);
    check_stream("basic", 6'd0, 8'h10, 4);
    for (int i = 0; i < 4 && i < enb_c.size(); i++) begin
      checks++;
      if (enb_c[i] != c0 + i) begin
        bad++; $display("FAIL basic_enb_cycle%0d: got T+%0d, required T+%0d", i, enb_c[i] - c0 + 1, i + 1);
      end
    end
    for (int i = 0; i < 4 && i < beats.size(); i++) begin
      checks++;
      if (beats[i].c != c0 + 2 + i) begin
        bad++; $display("FAIL basic_beat_cycle%0d: got T+%0d, required T+%0d", i, beats[i].c - c0 + 1, i + 3);
      end
    end
    if (done_c.size() > 0) begin
      checks++;
      if (done_c[0] != c0 + 6) begin
        bad++; $display("FAIL basic_done_cycle: got T+%0d, required T+7", done_c[0] - c0 + 1);
      end
    end
  endtask

  task automatic test_wrap();
    int c0;
    issue(6'd62, 8'hFE, 7'd4, c0);
    wait_done(40);
    check_stream("wrap", 6'd62, 8'hFE, 4);
  endtask

  task automatic test_backpressure();
    int c0;
    int k = 0;
    issue(6'd20, 8'h40, 7'd8, c0);
    while (done_c.size() == 0 && k < 200) begin
      @(posedge clk); #1;
      m_ready = (k % 3 == 2);
      k++;
    end
    m_ready = 1'b1;
    wait_done(10);
    check_stream("stall", 6'd20, 8'h40, 8);
  endtask

  task automatic test_len_zero();
    int c0;
    issue(6'd5, 8'h00, 7'd0, c0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL len0_done: done=%b busy=%b, required done=1 busy=0", done, busy);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (enb_a.size() != 0 || beats.size() != 0 || done_c.size() != 1) begin
      bad++; $display("FAIL len0_activity: reads=%0d beats=%0d dones=%0d, required 0 0 1",
                      enb_a.size(), beats.size(), done_c.size());
    end
  endtask

  task automatic test_start_while_busy();
    int c0;
    issue(6'd10, 8'h60, 7'd3, c0);
    src_base = 6'd30; dst_base = 8'h99; len = 7'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(40);
    repeat (6) @(negedge clk);
    check_stream("busy_start", 6'd10, 8'h60, 3);
  endtask

  task automatic test_mid_reset();
    int c0;
    int k = 0;
    issue(6'd5, 8'h80, 7'd6, c0);
    while (beats.size() < 2 && k < 40) begin @(negedge clk); k++; end
    checks++;
    if (beats.size() < 2) begin bad++; $display("FAIL mreset_prebeats: got %0d, required 2", beats.size()); end
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("mid_reset_values");
    reset_n = 1'b1;
    clear_logs();
    repeat (8) @(negedge clk);
    checks++;
    if (done_c.size() != 0 || beats.size() != 0 || enb_a.size() != 0) begin
      bad++; $display("FAIL mreset_quiet: dones=%0d beats=%0d reads=%0d, required 0 0 0",
                      done_c.size(), beats.size(), enb_a.size());
    end
    issue(6'd0, 8'h20, 7'd2, c0);
    wait_done(40);
    check_stream("after_reset", 6'd0, 8'h20, 2);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_len_zero();
    test_start_while_busy();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", checks, bad);
    $finish;
  end

endmodule
